// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared record types and decode constants for the commit tracer
package commit_trace_pkg;
  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_REG   = 2'd1,
    KIND_STORE = 2'd2
  } trace_kind_e;
  typedef struct packed {
    trace_kind_e kind;
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } trace_rec_t;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
endpackage

// File: rtl/commit_trace_fmt.sv
// commit_trace_fmt: per-lane keep filter and trace record formatter (seq left 0)
module commit_trace_fmt
  import commit_trace_pkg::*;
#(
  parameter logic [31:0] PC_MIN = 32'h2000
) (
  input  logic        valid,
  input  logic        en,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [5:0]  rd,
  input  logic [31:0] data,
  input  logic        st,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_mask,
  output logic        keep,
  output trace_rec_t  rec
);
  logic        is_reg;
  logic [31:0] d;
  logic [31:0] nd;
  assign is_reg = rd != 6'd0 && inst[6:2] != OPC_BRANCH;
  assign keep   = valid && en && pc >= PC_MIN && (st || is_reg);
  assign d      = st_data >> {st_addr[1:0], 3'b000};
  assign nd     = inst[14:12] == FUNCT3_SB ? d & 32'hFF : inst[14:12] == FUNCT3_SH ? d & 32'hFFFF : d;
  always_comb begin
    rec      = '0;
    rec.kind = !keep ? KIND_NONE : st ? KIND_STORE : KIND_REG;
    rec.pc   = pc;
    rec.inst = inst;
    rec.rd   = st ? 6'd0 : rd;
    rec.addr = st ? st_addr : 32'd0;
    rec.data = st ? nd : data;
    rec.mask = st ? st_mask : 4'd0;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: multi-lane commit tracer compacting kept lanes into a FIFO drained over valid/ready
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int          COMMIT_W   = 2,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] PC_MIN     = 32'h2000,
  parameter int          DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic [COMMIT_W-1:0]   commit_valid,
  input  logic [32*COMMIT_W-1:0] commit_pc,
  input  logic [32*COMMIT_W-1:0] commit_inst,
  input  logic [6*COMMIT_W-1:0] commit_Ard,
  input  logic [32*COMMIT_W-1:0] commit_data,
  input  logic [COMMIT_W-1:0]   st_commit,
  input  logic [32*COMMIT_W-1:0] st_addr,
  input  logic [32*COMMIT_W-1:0] st_data,
  input  logic [4*COMMIT_W-1:0] st_mask,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [1:0]            trace_kind,
  output logic [31:0]           trace_seq,
  output logic [31:0]           trace_pc,
  output logic [31:0]           trace_inst,
  output logic [5:0]            trace_rd,
  output logic [31:0]           trace_addr,
  output logic [31:0]           trace_data,
  output logic [3:0]            trace_mask,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  trace_rec_t          lrec [COMMIT_W];
  trace_rec_t          wrec [COMMIT_W];
  trace_rec_t          mem  [DEPTH];
  trace_rec_t          head;
  logic [COMMIT_W-1:0] keep;
  logic [AW:0]         off  [COMMIT_W];
  logic [AW:0]         n_keep;
  logic [AW:0]         count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [31:0]         seq_cnt;
  logic                accept;
  logic                pop;
  for (genvar l = 0; l < COMMIT_W; l++) begin : g_lane
    commit_trace_fmt #(.PC_MIN(PC_MIN)) u_fmt (
      .valid  (commit_valid[l]),
      .en     (trace_en),
      .pc     (commit_pc[32*l +: 32]),
      .inst   (commit_inst[32*l +: 32]),
      .rd     (commit_Ard[6*l +: 6]),
      .data   (commit_data[32*l +: 32]),
      .st     (st_commit[l]),
      .st_addr(st_addr[32*l +: 32]),
      .st_data(st_data[32*l +: 32]),
      .st_mask(st_mask[4*l +: 4]),
      .keep   (keep[l]),
      .rec    (lrec[l])
    );
  end
  // Exclusive prefix sum: each kept lane's slot offset from wr_ptr, which is also its seq offset
  always_comb begin
    n_keep = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      off[i]      = n_keep;
      wrec[i]     = lrec[i];
      wrec[i].seq = seq_cnt + 32'(n_keep);
      n_keep      = n_keep + (AW+1)'(keep[i]);
    end
  end
  // Free space uses the registered count only; a same-cycle pop is not credited
  assign accept      = n_keep <= (AW+1)'(DEPTH) - count;
  assign trace_valid = count != '0;
  assign pop         = trace_valid && trace_ready;
  assign almost_full = count >= (AW+1)'(DEPTH - COMMIT_W);
  assign head        = trace_valid ? mem[rd_ptr] : '0;
  assign trace_kind  = head.kind;
  assign trace_seq   = head.seq;
  assign trace_pc    = head.pc;
  assign trace_inst  = head.inst;
  assign trace_rd    = head.rd;
  assign trace_addr  = head.addr;
  assign trace_data  = head.data;
  assign trace_mask  = head.mask;
  always_ff @(posedge clk) begin
    if (rst && accept)
      for (int i = 0; i < COMMIT_W; i++)
        if (keep[i]) mem[wr_ptr + off[i][AW-1:0]] <= wrec[i];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + n_keep[AW-1:0];
      else begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + (accept ? n_keep : '0) - (AW+1)'(pop);
      seq_cnt <= seq_cnt + 32'(n_keep);
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed plus random stimulus checked against a queue-based reference model
module tb_commit_trace_buffer;
  localparam int          W      = 2;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] PC_MIN = 32'h2000;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trace_en = 1'b1;
  logic [W-1:0]  commit_valid = '0;
  logic [32*W-1:0] commit_pc = '0;
  logic [32*W-1:0] commit_inst = '0;
  logic [6*W-1:0] commit_Ard = '0;
  logic [32*W-1:0] commit_data = '0;
  logic [W-1:0]  st_commit = '0;
  logic [32*W-1:0] st_addr = '0;
  logic [32*W-1:0] st_data = '0;
  logic [4*W-1:0] st_mask = '0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [1:0]    trace_kind;
  logic [31:0]   trace_seq, trace_pc, trace_inst, trace_addr, trace_data;
  logic [5:0]    trace_rd;
  logic [3:0]    trace_mask;
  logic          almost_full, overflow;
  logic [15:0]   drop_cnt;
  int            checks = 0;
  int            errors = 0;
  logic [171:0]  q[$];
  logic [31:0]   m_seq = '0;
  logic          m_ovf = 1'b0;
  logic [15:0]   m_drop = '0;
  commit_trace_buffer dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_Ard(commit_Ard),
    .commit_data(commit_data), .st_commit(st_commit), .st_addr(st_addr),
    .st_data(st_data), .st_mask(st_mask), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_seq(trace_seq),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_rd(trace_rd),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_mask(trace_mask),
    .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [171:0] got, logic [171:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit lane_keep(int i);
    logic [31:0] pc, inst;
    pc   = commit_pc[32*i +: 32];
    inst = commit_inst[32*i +: 32];
    if (!(commit_valid[i] && trace_en && pc >= PC_MIN)) return 1'b0;
    if (st_commit[i]) return 1'b1;
    return commit_Ard[6*i +: 6] != 6'd0 && inst[6:2] != 5'b11000;
  endfunction
  function automatic logic [171:0] lane_rec(int i, logic [31:0] seq);
    logic [31:0] pc, inst, sa, d;
    pc   = commit_pc[32*i +: 32];
    inst = commit_inst[32*i +: 32];
    sa   = st_addr[32*i +: 32];
    if (!st_commit[i])
      return {2'b01, seq, pc, inst, commit_Ard[6*i +: 6], 32'd0, commit_data[32*i +: 32], 4'd0};
    d = st_data[32*i +: 32] >> (8 * sa[1:0]);
    if (inst[14:12] == 3'd0) d = d & 32'hFF;
    else if (inst[14:12] == 3'd1) d = d & 32'hFFFF;
    return {2'b10, seq, pc, inst, 6'd0, sa, d, st_mask[4*i +: 4]};
  endfunction
  // Check outputs against model state, advance the model by one clock, then let the DUT take the edge
  task automatic step();
    logic [171:0] recs[$];
    int cnt;
    @(negedge clk);
    chk("valid", trace_valid, q.size() != 0);
    chk("head", {trace_kind, trace_seq, trace_pc, trace_inst, trace_rd, trace_addr, trace_data, trace_mask},
        q.size() != 0 ? q[0] : '0);
    chk("almost_full", almost_full, q.size() >= DEPTH - W);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (!rst) begin
      q.delete();
      m_seq = '0;
      m_ovf = 1'b0;
      m_drop = '0;
    end else begin
      cnt = q.size();
      for (int i = 0; i < W; i++)
        if (lane_keep(i)) recs.push_back(lane_rec(i, m_seq + 32'(recs.size())));
      if (cnt != 0 && trace_ready) void'(q.pop_front());
      if (recs.size() > DEPTH - cnt) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop++;
      end else foreach (recs[k]) q.push_back(recs[k]);
      m_seq += 32'(recs.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clear_lanes();
    commit_valid = '0;
    st_commit = '0;
  endtask
  task automatic set_lane(int i, logic [31:0] pc, logic [31:0] inst, logic [5:0] rd, logic [31:0] data,
                          logic st, logic [31:0] sa, logic [31:0] sd, logic [3:0] sm);
    commit_valid[i] = 1'b1;
    commit_pc[32*i +: 32] = pc;
    commit_inst[32*i +: 32] = inst;
    commit_Ard[6*i +: 6] = rd;
    commit_data[32*i +: 32] = data;
    st_commit[i] = st;
    st_addr[32*i +: 32] = sa;
    st_data[32*i +: 32] = sd;
    st_mask[4*i +: 4] = sm;
  endtask
  task automatic rand_lane(int i);
    logic [31:0] inst;
    inst = $urandom;
    if ($urandom_range(0, 3) == 0) inst[6:2] = 5'b11000;
    set_lane(i, $urandom_range(32'h1FF0, 32'h2030) & ~32'h3, inst, 6'($urandom_range(0, 3)), $urandom,
             $urandom_range(0, 2) == 0, $urandom, $urandom, 4'($urandom));
    commit_valid[i] = $urandom_range(0, 4) != 0;
  endtask
  task automatic do_reset();
    clear_lanes();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    set_lane(0, 32'h2000, 32'h13, 6'd7, 32'h1, 1'b0, 0, 0, 0);
    step();
    rst = 1'b1;
    clear_lanes();
    step();
    chk("reset_no_push", trace_valid, 1'b0);
    chk("reset_data", {trace_seq, trace_data}, '0);
    trace_ready = 1'b1;
    set_lane(0, 32'h2000, 32'h0000_0013, 6'd5, 32'hDEADBEEF, 1'b0, 0, 0, 0);
    set_lane(1, 32'h2004, 32'h0000_0023, 6'd9, 32'h0, 1'b1, 32'h808F, 32'h7800_0000, 4'b1000);
    step();
    clear_lanes();
    chk("tp1_rd", {trace_kind, trace_rd, trace_data}, {2'b01, 6'd5, 32'hDEADBEEF});
    chk("tp1_seq0", trace_seq, 32'd0);
    step();
    chk("tp1_store", {trace_kind, trace_seq, trace_addr, trace_data, trace_rd},
        {2'b10, 32'd1, 32'h808F, 32'h78, 6'd0});
    step();
    do_reset();
    trace_ready = 1'b0;
    set_lane(0, 32'h1FFC, 32'h13, 6'd2, 32'h11, 1'b0, 0, 0, 0);
    set_lane(1, 32'h2004, 32'h13, 6'd3, 32'h22, 1'b0, 0, 0, 0);
    step();
    clear_lanes();
    chk("filt_rec", {trace_valid, trace_rd, trace_seq}, {1'b1, 6'd3, 32'd0});
    set_lane(0, 32'h2008, 32'h13, 6'd0, 32'h33, 1'b0, 0, 0, 0);
    set_lane(1, 32'h200C, 32'h63, 6'd1, 32'h44, 1'b0, 0, 0, 0);
    step();
    clear_lanes();
    trace_ready = 1'b1;
    repeat (3) step();
    do_reset();
    trace_ready = 1'b0;
    for (int g = 0; g < 9; g++) begin
      set_lane(0, 32'h3000 + 8 * g, 32'h13, 6'd1, g, 1'b0, 0, 0, 0);
      set_lane(1, 32'h3004 + 8 * g, 32'h13, 6'd2, g, 1'b0, 0, 0, 0);
      step();
      if (g == 5) chk("af_below", almost_full, 1'b0);
      if (g == 6) chk("af_at_14", almost_full, 1'b1);
    end
    clear_lanes();
    chk("ovf_flags", {overflow, drop_cnt}, {1'b1, 16'd1});
    trace_ready = 1'b1;
    step();
    set_lane(0, 32'h4000, 32'h13, 6'd4, 32'h55, 1'b0, 0, 0, 0);
    step();
    clear_lanes();
    repeat (18) step();
    for (int c = 0; c < 40; c++) begin
      trace_ready = c[0];
      set_lane(0, 32'h5000 + 4 * c, 32'h13, 6'd6, $urandom, 1'b0, 0, 0, 0);
      step();
    end
    clear_lanes();
    do_reset();
    trace_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 32'h6000 + 4 * c, 32'h13, 6'd8, c, 1'b0, 0, 0, 0);
      step();
    end
    clear_lanes();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_reset", {trace_valid, overflow, drop_cnt}, '0);
    set_lane(0, 32'h7000, 32'h13, 6'd10, 32'h77, 1'b0, 0, 0, 0);
    step();
    clear_lanes();
    chk("mid_reset_seq", {trace_valid, trace_seq}, {1'b1, 32'd0});
    for (int c = 0; c < 400; c++) begin
      rand_lane(0);
      rand_lane(1);
      trace_en = $urandom_range(0, 7) != 0;
      trace_ready = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 59) != 0;
      step();
    end
    rst = 1'b1;
    trace_en = 1'b1;
    clear_lanes();
    trace_ready = 1'b1;
    repeat (DEPTH + 2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Multi-lane commit tracer. Captures up to COMMIT_W retired instructions per cycle, filters and formats each into a trace record, and buffers them in program order in a DEPTH-entry FIFO.
- Records drain one per cycle over a valid/ready port to a trace sink (file writer, debug DMA or UART bridge).
- Sits beside the ROB retire stage and is synthesisable; it replaces simulation-only $fwrite logging.

Parameters:
- COMMIT_W, 2, number of retire lanes; lane 0 is oldest.
- DEPTH, 16, FIFO entries; power of two, DEPTH >= 2*COMMIT_W.
- PC_MIN, 32'h2000, commits with pc < PC_MIN are filtered out.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; state clears on the rising clk edge while rst==0.
- trace_en  in  1  enables capture; 0 means all commits are ignored.
- commit_valid  in  COMMIT_W  per-lane retire valid.
- commit_pc  in  32*COMMIT_W  retired PC, lane i at [32i+31:32i]; same packing for the other wide commit ports.
- commit_inst  in  32*COMMIT_W  instruction word.
- commit_Ard  in  6*COMMIT_W  architectural destination register.
- commit_data  in  32*COMMIT_W  writeback data.
- st_commit  in  COMMIT_W  lane retires a store.
- st_addr  in  32*COMMIT_W  store address.
- st_data  in  32*COMMIT_W  store data, lane-aligned as on the memory bus.
- st_mask  in  4*COMMIT_W  byte strobes.
- trace_valid  out  1  head record valid.
- trace_ready  in  1  sink accepts the head record.
- trace_kind  out  2  record kind: 01 REG, 10 STORE.
- trace_seq  out  32  record sequence number.
- trace_pc  out  32  PC.
- trace_inst  out  32  instruction word.
- trace_rd  out  6  destination register; 0 for STORE records.
- trace_addr  out  32  store address; 0 for REG records.
- trace_data  out  32  register data, or store data after normalisation.
- trace_mask  out  4  store strobes; 0 for REG records.
- almost_full  out  1  count >= DEPTH-COMMIT_W; the core uses it to stall retire.
- overflow  out  1  sticky; set on any dropped group.
- drop_cnt  out  DROP_CNT_W  count of dropped groups, saturating at all-ones.

Behaviour:
- Reset (rst==0 at clk edge):
  - FIFO empty.
  - seq counter = 0.
  - overflow = 0.
  - drop_cnt = 0.
  - trace_valid = 0.
  - All trace_* data outputs = 0.
  - almost_full = 0.
  - A push or pop in the reset cycle is discarded.
- Lane keep rule: valid && trace_en && pc >= PC_MIN, and one of:
  - st_commit=1 gives a STORE record. Store takes priority.
  - Ard != 0 and inst[6:2] != 5'b11000 gives a REG record.
  - Otherwise the lane is discarded.
- STORE normalisation:
  - d = st_data >> (8*st_addr[1:0]).
  - funct3 = inst[14:12]: 000 gives d & 32'hFF; 001 gives d & 32'hFFFF; anything else gives d unmasked.
- Compaction:
  - Kept lanes are written to consecutive FIFO slots in lane order, with no holes.
  - n_keep ranges 0..COMMIT_W.
- Sequence numbers:
  - Kept lane k in the group (k = 0..n_keep-1) gets seq = seq_cnt + k.
  - seq_cnt advances by n_keep every cycle, including dropped cycles, so the sink sees gaps.
  - The counter wraps modulo 2^32.
- Space check (all-or-nothing):
  - free = DEPTH - count, using the registered count. A pop in the same cycle is not credited.
  - n_keep <= free: push the whole group.
  - Otherwise: push nothing, set overflow=1, and drop_cnt += 1 (saturating).
  - n_keep == 0 never counts as a drop.
- Pop:
  - Occurs when trace_valid && trace_ready.
  - The head advances at the clk edge.
  - Outputs are registered from FIFO storage; a record is visible 1 cycle after its push (latency 1, no bypass).
- Simultaneous push and pop:
  - count_next = count + n_push - pop.
  - Pointers wrap modulo DEPTH.
- Sink handshake:
  - trace_valid stays 1 and all trace_* fields stay stable until ready is seen.
  - trace_valid = (count != 0).
- trace_en=0: capture stops, but draining continues.
- Reset mid-drain: all pending records are lost and the seq counter restarts at 0.

Decomposition:
- commit_trace_pkg holds:
  - trace_kind_e (KIND_NONE=0, KIND_REG=1, KIND_STORE=2).
  - trace_rec_t packed struct {kind, seq, pc, inst, rd, addr, data, mask}.
  - OPC_BRANCH = 5'b11000.
  - FUNCT3_SB = 3'b000, FUNCT3_SH = 3'b001.
- Sub-module commit_trace_fmt: combinational, one per lane. It applies the keep rule and store normalisation and outputs keep + trace_rec_t (seq filled by the parent).
- The parent holds the compaction prefix-sum, FIFO, counters and handshake.

Test Plan:
- Two lanes kept, both pushed:
  - Stimulus: lane0 REG pc=0x2000, Ard=5, data=0xDEADBEEF; lane1 STORE sb to addr 0x808F, st_data=0x78000000, funct3=000; sink ready.
  - Response: seq0 REG x5 0xDEADBEEF, then next cycle seq1 STORE addr 0x808F data 0x00000078.
- Filtering and compaction:
  - Stimulus: lane0 pc=0x1FFC (below PC_MIN); lane1 REG pc=0x2004, Ard=3.
  - Response: exactly one record, REG x3, seq=0.
- Non-loggable lanes:
  - Stimulus: lane0 has Ard=0; lane1 is a branch with Ard=1 (inst[6:2]=11000).
  - Response: no record, and seq_cnt is unchanged.
- Overflow:
  - Stimulus: ready=0; fill 16 records with 8 two-lane groups; then push one more two-lane group.
  - Response: almost_full=1 once count reaches 14; the ninth group is dropped; overflow=1; drop_cnt=1; seq of the next accepted record = 18.
- Back-pressure:
  - Stimulus: toggle ready 1/0 every cycle while pushing one record per cycle.
  - Response: no record lost or duplicated; fields stay stable while ready=0; count never exceeds DEPTH.
- Mid-stream reset:
  - Stimulus: rst=0 for 1 cycle with 5 records queued.
  - Response: trace_valid=0, count=0, overflow=0, drop_cnt=0; the next record has seq=0.
